// File: rtl/synth_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | synth_pkg : types and constants shared by the I2S transmitter and receiver |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
package synth_pkg;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } i2s_rx_state_t;

  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sync_edge : N-stage synchronizer with a registered rising-edge strobe      |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;
  logic              rise_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      last_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      last_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~last_q;
    end
  end

  assign rise = rise_q;

endmodule
`default_nettype wire

// File: rtl/i2s_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | i2s_receiver : I2S serial-to-parallel stereo receiver with framing checks  |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
module i2s_receiver
  import synth_pkg::*;
#(
  parameter int NUM_BITS    = 24,
  parameter int SLOT_BITS   = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_clk,
  input  logic                word_select,
  input  logic                serial_data,
  output logic [NUM_BITS-1:0] left_out,
  output logic [NUM_BITS-1:0] right_out,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                frame_err,
  output logic                overrun
);

  localparam int                  POS_W      = $clog2(2*SLOT_BITS+1);
  localparam logic [POS_W-1:0]    POS_MAX    = POS_W'(2*SLOT_BITS);
  localparam logic [POS_W-1:0]    POS_PRE    = POS_W'(2*SLOT_BITS-1);
  localparam logic [POS_W-1:0]    SLOT_LEN   = POS_W'(SLOT_BITS);
  localparam logic [NUM_BITS-1:0] MSB_MASK   = NUM_BITS'(1) << (NUM_BITS-1);

  logic [SYNC_STAGES-1:0] ws_sync_q;
  logic [SYNC_STAGES-1:0] sd_sync_q;
  logic                   ws_al_q;
  logic                   sd_al_q;
  logic                   w_bit_pos;

  logic                   ws_prev_q;
  logic                   ws_d_q;
  logic [POS_W-1:0]       pos_q;
  logic [POS_W-1:0]       pos_d;
  logic [NUM_BITS-1:0]    shreg_q;
  logic [NUM_BITS-1:0]    shreg_d;
  logic [NUM_BITS-1:0]    mask_q;
  logic [NUM_BITS-1:0]    mask_d;
  logic [NUM_BITS-1:0]    left_pend_q;
  logic                   bad_q;
  i2s_rx_state_t          state_q;

  logic [NUM_BITS-1:0]    left_q;
  logic [NUM_BITS-1:0]    right_q;
  logic                   valid_q;
  logic                   frame_err_q;
  logic                   overrun_q;

  logic                   w_ws_d;
  logic                   w_change;
  logic                   w_len_ok;
  logic                   w_stuck;

  sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (s_clk),
    .rise (w_bit_pos)
  );

  // One extra register on WS/SD matches the strobe's edge-detect stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ws_sync_q <= '0;
      sd_sync_q <= '0;
      ws_al_q   <= 1'b0;
      sd_al_q   <= 1'b0;
    end else begin
      ws_sync_q[0] <= word_select;
      sd_sync_q[0] <= serial_data;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        ws_sync_q[i] <= ws_sync_q[i-1];
        sd_sync_q[i] <= sd_sync_q[i-1];
      end
      ws_al_q <= ws_sync_q[SYNC_STAGES-1];
      sd_al_q <= sd_sync_q[SYNC_STAGES-1];
    end
  end

  assign w_ws_d   = ws_prev_q;
  assign w_change = w_bit_pos & (w_ws_d != ws_d_q);
  assign w_len_ok = (pos_q == SLOT_LEN);
  assign w_stuck  = w_bit_pos & ~w_change & (pos_q == POS_PRE);

  // Slot capture: a one-hot mask walks from MSB to LSB; once it empties the
  // remaining slot bits are ignored and unfilled LSBs stay zero.
  always_comb begin
    pos_d   = pos_q;
    shreg_d = shreg_q;
    mask_d  = mask_q;
    if (w_change) begin
      pos_d   = POS_W'(1);
      shreg_d = sd_al_q ? MSB_MASK : '0;
      mask_d  = MSB_MASK >> 1;
    end else if (w_bit_pos) begin
      pos_d   = (pos_q == POS_MAX) ? pos_q : pos_q + POS_W'(1);
      shreg_d = shreg_q | (sd_al_q ? mask_q : '0);
      mask_d  = mask_q >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ws_prev_q   <= 1'b0;
      ws_d_q      <= 1'b0;
      pos_q       <= '0;
      shreg_q     <= '0;
      mask_q      <= '0;
      left_pend_q <= '0;
      bad_q       <= 1'b0;
      state_q     <= HUNT;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      if (valid_q && sample_ready) begin
        valid_q <= 1'b0;
      end
      pos_q   <= pos_d;
      shreg_q <= shreg_d;
      mask_q  <= mask_d;
      if (w_bit_pos) begin
        ws_prev_q <= ws_al_q;
        ws_d_q    <= w_ws_d;
      end

      case (state_q)
        HUNT: begin
          if (w_change && w_ws_d == WS_LEFT) begin
            state_q <= LEFT;
            bad_q   <= 1'b0;
          end
        end
        LEFT: begin
          if (w_change && w_ws_d == WS_RIGHT) begin
            left_pend_q <= shreg_q;
            bad_q       <= ~w_len_ok;
            state_q     <= RIGHT;
          end
        end
        RIGHT: begin
          if (w_change && w_ws_d == WS_LEFT) begin
            state_q <= LEFT;
            bad_q   <= 1'b0;
            if (bad_q || !w_len_ok) begin
              frame_err_q <= 1'b1;
            end else if (!valid_q || sample_ready) begin
              left_q  <= left_pend_q;
              right_q <= shreg_q;
              valid_q <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
          end
        end
        default: state_q <= HUNT;
      endcase

      if (w_stuck) begin
        frame_err_q <= 1'b1;
        state_q     <= HUNT;
      end
    end
  end

  assign left_out     = left_q;
  assign right_out    = right_q;
  assign sample_valid = valid_q;
  assign frame_err    = frame_err_q;
  assign overrun      = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_i2s_receiver : self-checking bench for i2s_receiver                     |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
module tb_i2s_receiver;

  localparam int NB = 24;
  localparam int SB = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          s_clk = 1'b0;
  logic          word_select = 1'b0;
  logic          serial_data = 1'b0;
  logic          sample_ready = 1'b0;
  logic [NB-1:0] left_out;
  logic [NB-1:0] right_out;
  logic          sample_valid;
  logic          frame_err;
  logic          overrun;

  always #5 clk = ~clk;

  i2s_receiver #(
    .NUM_BITS    (NB),
    .SLOT_BITS   (SB),
    .SYNC_STAGES (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_clk        (s_clk),
    .word_select  (word_select),
    .serial_data  (serial_data),
    .left_out     (left_out),
    .right_out    (right_out),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .frame_err    (frame_err),
    .overrun      (overrun)
  );

  int errors = 0;
  int checks = 0;

  bit              q_ch[$];
  bit              q_sd[$];
  logic [2*NB-1:0] got[$];
  logic [2*NB-1:0] exp_q[$];
  int              exp_ferr;
  int              ferr_cnt;
  int              ovr_cnt;

  int              mark_idx;
  bit              mark_ready;
  logic            snap3_valid;
  logic            snap4_valid;
  logic            snap4_ferr;
  logic            snap4_ovr;
  logic [2*NB-1:0] snap4_pair;

  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      if (sample_valid && sample_ready) got.push_back({left_out, right_out});
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
    end
  end

  task automatic add_slot(input bit c, input int len, input logic [NB-1:0] w);
    for (int i = 0; i < len; i++) begin
      q_ch.push_back(c);
      q_sd.push_back(i < NB ? w[NB-1-i] : 1'($urandom));
    end
  endtask

  task automatic add_frame(input logic [NB-1:0] l, input logic [NB-1:0] r);
    add_slot(1'b0, SB, l);
    add_slot(1'b1, SB, r);
  endtask

  // Slot-level view: split the channel stream into runs, close each run at
  // the next channel change, and apply the framing rules per run.
  task automatic run_model;
    int st;
    int start;
    int len;
    bit bad;
    logic [NB-1:0] pend;
    logic [NB-1:0] w;
    exp_q.delete();
    exp_ferr = 0;
    st = 0;
    bad = 1'b0;
    pend = '0;
    start = 0;
    for (int n = 1; n <= q_ch.size(); n++) begin
      if (n == q_ch.size() || q_ch[n] != q_ch[n-1]) begin
        len = n - start;
        w = '0;
        for (int i = 0; i < len && i < NB; i++) w[NB-1-i] = q_sd[start+i];
        if (len >= 2*SB) begin
          exp_ferr++;
          st = 0;
        end
        if (n < q_ch.size()) begin
          if (st == 0) begin
            if (q_ch[n] == 1'b0) begin st = 1; bad = 1'b0; end
          end else if (st == 1) begin
            pend = w;
            bad = (len != SB);
            st = 2;
          end else begin
            if (bad || len != SB) exp_ferr++;
            else exp_q.push_back({pend, w});
            st = 1;
            bad = 1'b0;
          end
        end
        start = n;
      end
    end
  endtask

  task automatic drive_stream;
    snap3_valid = 1'bx;
    snap4_valid = 1'bx;
    snap4_ferr  = 1'bx;
    snap4_ovr   = 1'bx;
    snap4_pair  = 'x;
    @(negedge clk);
    for (int n = 0; n < q_ch.size(); n++) begin
      s_clk = 1'b0;
      word_select = (n + 1 < q_ch.size()) ? q_ch[n+1] : q_ch[n];
      serial_data = q_sd[n];
      repeat (4) @(negedge clk);
      s_clk = 1'b1;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        if (n == mark_idx && k == 3) begin
          snap3_valid = sample_valid;
          if (mark_ready) sample_ready = 1'b1;
        end
        if (n == mark_idx && k == 4) begin
          snap4_valid = sample_valid;
          snap4_ferr  = frame_err;
          snap4_ovr   = overrun;
          snap4_pair  = {left_out, right_out};
          if (mark_ready) sample_ready = 1'b0;
        end
      end
    end
    s_clk = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    got.delete();
    q_ch.delete();
    q_sd.delete();
    ferr_cnt = 0;
    ovr_cnt = 0;
    mark_idx = -1;
    mark_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (left_out !== '0) begin errors++; $display("FAIL reset_left: got %h want 0", left_out); end
    checks++; if (right_out !== '0) begin errors++; $display("FAIL reset_right: got %h want 0", right_out); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", sample_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0", overrun); end
    rst = 1'b1;
  endtask

  task automatic test_basic;
    do_reset();
    sample_ready = 1'b1;
    add_frame(NB'($urandom), NB'($urandom));
    add_frame(24'hA5A5A5, 24'h5A5A5A);
    add_slot(1'b0, 4, '0);
    mark_idx = 4*SB;
    run_model();
    drive_stream();
    checks++; if (got.size() != 1) begin errors++; $display("FAIL basic_count: got %0d pairs want 1", got.size()); end
    if (got.size() > 0) begin
      checks++; if (got[0] !== {24'hA5A5A5, 24'h5A5A5A}) begin errors++; $display("FAIL basic_pair: got %h want a5a5a55a5a5a", got[0]); end
    end
    checks++; if (snap3_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_early: got %b want 0", snap3_valid); end
    checks++; if (snap4_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_rise: got %b want 1", snap4_valid); end
    checks++; if (ferr_cnt !== 0) begin errors++; $display("FAIL basic_ferr: got %0d want 0", ferr_cnt); end
  endtask

  task automatic test_random;
    do_reset();
    sample_ready = 1'b1;
    add_frame(NB'($urandom), NB'($urandom));
    for (int f = 0; f < 10; f++) begin
      add_slot(1'b0, ($urandom % 4 == 0) ? int'($urandom_range(20, 40)) : SB, NB'($urandom));
      add_slot(1'b1, ($urandom % 4 == 0) ? int'($urandom_range(20, 40)) : SB, NB'($urandom));
    end
    add_slot(1'b0, 4, '0);
    run_model();
    drive_stream();
    checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL random_count: got %0d pairs want %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL random_pair%0d: got %h want %h", i, got[i], exp_q[i]); end
    end
    checks++; if (ferr_cnt !== exp_ferr) begin errors++; $display("FAIL random_ferr: got %0d want %0d", ferr_cnt, exp_ferr); end
    checks++; if (ovr_cnt !== 0) begin errors++; $display("FAIL random_ovr: got %0d want 0", ovr_cnt); end
  endtask

  task automatic test_backpressure;
    do_reset();
    sample_ready = 1'b0;
    add_frame(NB'($urandom), NB'($urandom));
    for (int f = 0; f < 3; f++) add_frame(NB'($urandom), NB'($urandom));
    add_slot(1'b0, 4, '0);
    run_model();
    drive_stream();
    checks++; if (ovr_cnt !== 2) begin errors++; $display("FAIL bp_overruns: got %0d want 2", ovr_cnt); end
    checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_held: got %b want 1", sample_valid); end
    checks++; if ({left_out, right_out} !== exp_q[0]) begin errors++; $display("FAIL bp_pair_held: got %h want %h", {left_out, right_out}, exp_q[0]); end
    sample_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_clear: got %b want 0", sample_valid); end
    checks++; if (got.size() != 1) begin errors++; $display("FAIL bp_count: got %0d pairs want 1", got.size()); end
    if (got.size() > 0) begin
      checks++; if (got[0] !== exp_q[0]) begin errors++; $display("FAIL bp_pair: got %h want %h", got[0], exp_q[0]); end
    end
  endtask

  task automatic test_simultaneous;
    do_reset();
    sample_ready = 1'b0;
    add_frame(NB'($urandom), NB'($urandom));
    add_frame(NB'($urandom), NB'($urandom));
    add_frame(NB'($urandom), NB'($urandom));
    add_slot(1'b0, 4, '0);
    mark_idx = 6*SB;
    mark_ready = 1'b1;
    run_model();
    drive_stream();
    checks++; if (got.size() != 1) begin errors++; $display("FAIL simul_count: got %0d pairs want 1", got.size()); end
    if (got.size() > 0) begin
      checks++; if (got[0] !== exp_q[0]) begin errors++; $display("FAIL simul_old_pair: got %h want %h", got[0], exp_q[0]); end
    end
    checks++; if (snap4_valid !== 1'b1) begin errors++; $display("FAIL simul_valid: got %b want 1", snap4_valid); end
    checks++; if (snap4_pair !== exp_q[1]) begin errors++; $display("FAIL simul_new_pair: got %h want %h", snap4_pair, exp_q[1]); end
    checks++; if (snap4_ovr !== 1'b0 || ovr_cnt !== 0) begin errors++; $display("FAIL simul_ovr: got %b/%0d want 0/0", snap4_ovr, ovr_cnt); end
  endtask

  task automatic test_short_slot;
    do_reset();
    sample_ready = 1'b1;
    add_frame(NB'($urandom), NB'($urandom));
    add_slot(1'b0, SB, NB'($urandom));
    add_slot(1'b1, 20, 24'hFFFFF0);
    add_frame(NB'($urandom), NB'($urandom));
    add_slot(1'b0, 4, '0);
    run_model();
    drive_stream();
    checks++; if (ferr_cnt !== 1) begin errors++; $display("FAIL short_ferr: got %0d want 1", ferr_cnt); end
    checks++; if (got.size() != 1) begin errors++; $display("FAIL short_count: got %0d pairs want 1", got.size()); end
    if (got.size() > 0) begin
      checks++; if (got[0] !== exp_q[0]) begin errors++; $display("FAIL short_next_pair: got %h want %h", got[0], exp_q[0]); end
    end
  endtask

  task automatic test_ws_stuck;
    do_reset();
    sample_ready = 1'b1;
    add_frame(NB'($urandom), NB'($urandom));
    add_frame(NB'($urandom), NB'($urandom));
    add_slot(1'b0, 70, NB'($urandom));
    add_slot(1'b1, SB, NB'($urandom));
    add_frame(NB'($urandom), NB'($urandom));
    add_slot(1'b0, 4, '0);
    mark_idx = 4*SB + 63;
    run_model();
    drive_stream();
    checks++; if (ferr_cnt !== 1) begin errors++; $display("FAIL stuck_ferr: got %0d want 1", ferr_cnt); end
    checks++; if (snap4_ferr !== 1'b1) begin errors++; $display("FAIL stuck_ferr_at_64: got %b want 1", snap4_ferr); end
    checks++; if (got.size() != 2 || exp_q.size() != 2) begin errors++; $display("FAIL stuck_count: got %0d pairs want 2", got.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL stuck_pair%0d: got %h want %h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_midframe;
    do_reset();
    sample_ready = 1'b0;
    add_frame(NB'($urandom), NB'($urandom));
    add_frame(NB'($urandom), NB'($urandom));
    add_slot(1'b0, SB, NB'($urandom));
    add_slot(1'b1, 16, NB'($urandom));
    drive_stream();
    checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid: got %b want 1", sample_valid); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if ({sample_valid, frame_err, overrun} !== 3'b000 || left_out !== '0 || right_out !== '0) begin
      errors++; $display("FAIL midrst_async: got v=%b fe=%b ov=%b l=%h r=%h want all 0", sample_valid, frame_err, overrun, left_out, right_out);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    got.delete();
    q_ch.delete();
    q_sd.delete();
    ferr_cnt = 0;
    ovr_cnt = 0;
    sample_ready = 1'b1;
    add_frame(NB'($urandom), NB'($urandom));
    add_frame(NB'($urandom), NB'($urandom));
    add_slot(1'b0, 4, '0);
    run_model();
    drive_stream();
    checks++; if (got.size() != 1) begin errors++; $display("FAIL midrst_count: got %0d pairs want 1", got.size()); end
    if (got.size() > 0) begin
      checks++; if (got[0] !== exp_q[0]) begin errors++; $display("FAIL midrst_pair: got %h want %h", got[0], exp_q[0]); end
    end
    checks++; if (ferr_cnt !== 0) begin errors++; $display("FAIL midrst_ferr: got %0d want 0", ferr_cnt); end
  endtask

  initial begin
    mark_idx = -1;
    mark_ready = 1'b0;
    ferr_cnt = 0;
    ovr_cnt = 0;
    test_reset();
    test_basic();
    test_random();
    test_backpressure();
    test_simultaneous();
    test_short_slot();
    test_ws_stuck();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2s_receiver.md
# i2s_receiver

Serial-to-parallel I2S receiver: the receive end of the same I2S link the synthesizer's transmitter drives, for ADC input and transmitter loopback test. It takes an external bit clock, word select and serial data, synchronizes them into `clk`, de-serializes stereo frames and delivers each complete left/right pair through a valid/ready handshake. It also detects framing faults and overruns.

## Interface
- `NUM_BITS`, 24: data bits kept per channel, MSB first.
- `SLOT_BITS`, 32: bit clocks per channel slot; any other slot length is a framing error. Must be ≥ `NUM_BITS`.
- `SYNC_STAGES`, 2: synchronizer depth for all three serial inputs.

- `clk` input 1: system clock. One clock domain only.
- `rst` input 1: asynchronous, active-low reset.
- `s_clk` input 1: external I2S bit clock. High and low phases are each ≥ 2 `clk` periods.
- `word_select` input 1: I2S WS. 0 = left, 1 = right.
- `serial_data` input 1: I2S SD.
- `left_out` output `NUM_BITS`: left sample, two's complement.
- `right_out` output `NUM_BITS`: right sample.
- `sample_valid` output 1: pair available. Held until accepted.
- `sample_ready` input 1: consumer accepts when `sample_valid & sample_ready`.
- `frame_err` output 1: 1-cycle pulse per framing fault.
- `overrun` output 1: 1-cycle pulse per dropped pair.

## Operation
- All three inputs pass through `SYNC_STAGES` flops. Each rising edge of synchronized `s_clk` produces a strobe `bit_pos`, and WS and SD are sampled at that strobe.
- I2S one-bit delay: `ws_d` is the WS value from the previous strobe. The bit sampled at a strobe belongs to channel `ws_d`.
- The bit position within a slot counts strobes since `ws_d` last changed; position 0 is the MSB.
  - Positions 0 to `NUM_BITS`-1 shift into the channel shift register.
  - Positions ≥ `NUM_BITS` are ignored.
- A change of `ws_d` at a strobe closes the current slot. Its length is the position count at that strobe.
- State machine (`HUNT`, `LEFT`, `RIGHT`). Reset enters `HUNT`.
  - `HUNT`: no capture. On `ws_d` 1→0, go to `LEFT` with position 0.
  - `LEFT`: on `ws_d` 0→1, latch the left word into the pending-left register and go to `RIGHT`. If slot length ≠ `SLOT_BITS`, mark the frame bad.
  - `RIGHT`: on `ws_d` 1→0, latch the right word, check the length, and go to `LEFT`.
    - Frame good: issue the pair.
    - Frame bad: pulse `frame_err`, drop the pair, and still go to `LEFT`, because the transition starts a valid left slot.
  - Any state: if the position counter reaches 2·`SLOT_BITS` (WS stuck), pulse `frame_err` and go to `HUNT`. The counter saturates and never wraps.
- Issuing a pair:
  - If `sample_valid`=0, or `sample_ready`=1 in the same cycle: load `left_out`/`right_out`, set `sample_valid`=1.
  - Otherwise keep the old pair unchanged and pulse `overrun`.
- `sample_valid` clears on handshake when no new pair issues in that cycle.

## Timing
- Reset values: `left_out`=0, `right_out`=0, `sample_valid`=0, `frame_err`=0, `overrun`=0, state `HUNT`, counters 0, synchronizers 0. All take effect immediately on `rst` low, independent of `clk`.
- Pin-to-strobe latency is `SYNC_STAGES`+1 `clk` cycles. WS and SD see the same delay, so they stay aligned.
- `sample_valid` rises on the `clk` edge after the strobe that closes the right slot. `frame_err` and `overrun` pulse on that same edge.
- Reset mid-frame discards the partial frame. The first pair delivered after release is the first frame whose left slot begins after a 1→0 WS edge observed in `HUNT`.
- Width rules:
  - Position counter is `$clog2(2*SLOT_BITS+1)` bits.
  - When `NUM_BITS` > slot length, the unfilled LSBs are zero, and the frame is still flagged as a length error.

## Structure
- Shared package `synth_pkg` holds:
  - the state enum `i2s_rx_state_t` (`HUNT`, `LEFT`, `RIGHT`);
  - the WS channel constants `WS_LEFT`=0 and `WS_RIGHT`=1, shared with the transmitter.
- Sub-module `sync_edge`: an N-stage synchronizer with a rising-edge strobe output, instantiated for `s_clk`. WS and SD use plain synchronizers of equal depth.

## Test plan
All scenarios use `NUM_BITS`=24 and `SLOT_BITS`=32.
- **Basic frame:** `s_clk`=`clk`/8, left 0xA5A5A5, right 0x5A5A5A. Expect:
  - the first frame after reset ignored (`HUNT`);
  - the next frame gives `left_out`=0xA5A5A5, `right_out`=0x5A5A5A;
  - `sample_valid` rising one `clk` after the closing strobe, and `frame_err` never asserted.
- **Backpressure:** `sample_ready` low across 3 frames. Expect the first pair held unchanged and exactly 2 `overrun` pulses. Raising ready then gives the handshake and `sample_valid`=0 until the next frame.
- **Simultaneous events:** `sample_ready`=1 in the same cycle a new pair issues. Expect the new pair loaded, `sample_valid` staying 1, and no `overrun`.
- **Short slot:** a right slot of 20 bits carrying 0xFFFFF. Expect:
  - one `frame_err` pulse and no `sample_valid`;
  - the next well-formed frame delivered normally.
- **WS stuck:** WS held at 0 for 70 bit clocks. Expect one `frame_err` pulse at the 64th strobe and a return to `HUNT`. Recovery takes one discarded frame, then correct data.
- **Reset mid-frame:** `rst` pulsed low mid right slot. Expect all outputs 0 asynchronously and the partial frame never delivered.
